// File: rtl/coherence_bus_arbiter.sv
// Coherence bus arbiter and tenure controller.
// Grants the shared L1<->L2 bus to one L1 port, hands the mux to the L2 port
// for the response phase, then releases (or retains for HOLD_BUS) the tenure.
// A per-phase watchdog aborts hung tenures and records the offending port.
//
// Handshake: while req_ready is high (RESP phase) the L2 response on the bus
// is valid for the granted master; the master acknowledges it by driving
// HOLD_BUS (keep tenure for another phase) or NO_REQ (release). Any other
// master message leaves the response phase open.
module coherence_bus_arbiter #(
    parameter int NUM_CACHES     = 4,
    parameter int MSG_BITS       = 4,
    parameter int ARB_MODE       = 0,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TIMER_BITS     = 11,
    localparam int BUS_SIG_WIDTH = $clog2(NUM_CACHES + 1)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_CACHES*MSG_BITS-1:0] cache2mem_msg,
    input  logic [MSG_BITS-1:0]            mem2controller_msg,
    output logic [BUS_SIG_WIDTH-1:0]       bus_control,
    output logic                           bus_en,
    output logic [NUM_CACHES-1:0]          curr_master,
    output logic                           req_ready,
    output logic                           timeout_err,
    output logic [BUS_SIG_WIDTH-1:0]       timeout_port,
    output logic [1:0]                     dbg_state
);

    localparam int IDX_SLOTS = 2 ** BUS_SIG_WIDTH;

    localparam logic [MSG_BITS-1:0] NO_REQ     = '0;
    localparam logic [MSG_BITS-1:0] MEM_RESP   = MSG_BITS'(10);
    localparam logic [MSG_BITS-1:0] MEM_RESP_S = MSG_BITS'(11);
    localparam logic [MSG_BITS-1:0] MEM_C_RESP = MSG_BITS'(12);
    localparam logic [MSG_BITS-1:0] REQ_FLUSH  = MSG_BITS'(13);
    localparam logic [MSG_BITS-1:0] HOLD_BUS   = MSG_BITS'(14);

    localparam bit                    WD_EN    = (TIMEOUT_CYCLES != 0);
    localparam int                    WD_LIM_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [TIMER_BITS-1:0] WD_LIMIT = TIMER_BITS'(WD_LIM_I);

    localparam logic [BUS_SIG_WIDTH-1:0] MEM_PORT  = BUS_SIG_WIDTH'(NUM_CACHES);
    localparam logic [BUS_SIG_WIDTH-1:0] LAST_PORT = BUS_SIG_WIDTH'(NUM_CACHES - 1);

    // Encoding is visible on dbg_state: 0 idle, 1 master phase, 2 response phase.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MASTER = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [BUS_SIG_WIDTH-1:0]   m_q, m_d;
    logic [BUS_SIG_WIDTH-1:0]   last_grant_q, last_grant_d;
    logic [TIMER_BITS-1:0]      timer_q, timer_d;
    logic                       timeout_err_q, timeout_err_d;
    logic [BUS_SIG_WIDTH-1:0]   timeout_port_q, timeout_port_d;

    // Per-port views padded to a power of two so the master index selects directly.
    logic [IDX_SLOTS-1:0]       req_pad;
    logic [MSG_BITS-1:0]        msg_arr [IDX_SLOTS];
    logic [MSG_BITS-1:0]        cur_msg;
    logic                       l2_resp;
    logic                       grant_found;
    logic [BUS_SIG_WIDTH-1:0]   grant_idx;
    logic [BUS_SIG_WIDTH-1:0]   cand;

    // Split the request bus into per-port messages and request flags.
    always_comb begin
        req_pad = '0;
        for (int i = 0; i < IDX_SLOTS; i++) begin
            msg_arr[i] = NO_REQ;
        end
        for (int i = 0; i < NUM_CACHES; i++) begin
            msg_arr[i] = cache2mem_msg[i*MSG_BITS +: MSG_BITS];
            req_pad[i] = (cache2mem_msg[i*MSG_BITS +: MSG_BITS] != NO_REQ);
        end
        cur_msg = msg_arr[m_q];
        l2_resp = (mem2controller_msg == MEM_RESP)   || (mem2controller_msg == MEM_RESP_S) ||
                  (mem2controller_msg == MEM_C_RESP) || (mem2controller_msg == REQ_FLUSH);
    end

    // Pick the next master: rotating scan after last_grant, or lowest index first.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_CACHES; k++) begin
            if (ARB_MODE == 1) begin
                cand = BUS_SIG_WIDTH'(k);
            end else begin
                cand = BUS_SIG_WIDTH'((int'(last_grant_q) + 1 + k) % NUM_CACHES);
            end
            if (!grant_found && req_pad[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // State register: tenure state, master, fairness pointer, watchdog and abort report.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            m_q            <= '0;
            last_grant_q   <= LAST_PORT;
            timer_q        <= '0;
            timeout_err_q  <= 1'b0;
            timeout_port_q <= '0;
        end else begin
            state_q        <= state_d;
            m_q            <= m_d;
            last_grant_q   <= last_grant_d;
            timer_q        <= timer_d;
            timeout_err_q  <= timeout_err_d;
            timeout_port_q <= timeout_port_d;
        end
    end

    // Next-state logic: legal phase transitions first, watchdog abort only if none fired.
    always_comb begin
        state_d        = state_q;
        m_d            = m_q;
        last_grant_d   = last_grant_q;
        timeout_err_d  = 1'b0;
        timeout_port_d = timeout_port_q;
        timer_d        = timer_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    state_d = ST_MASTER;
                    m_d     = grant_idx;
                end
            end
            ST_MASTER: begin
                if (l2_resp) begin
                    state_d = ST_RESP;
                end else if (cur_msg == NO_REQ) begin
                    state_d      = ST_IDLE;
                    last_grant_d = m_q;
                end
            end
            ST_RESP: begin
                if (cur_msg == HOLD_BUS) begin
                    state_d = ST_MASTER;
                end else if (cur_msg == NO_REQ) begin
                    state_d      = ST_IDLE;
                    last_grant_d = m_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (WD_EN && (state_q != ST_IDLE) && (state_d == state_q) && (timer_q == WD_LIMIT)) begin
            state_d        = ST_IDLE;
            last_grant_d   = m_q;
            timeout_err_d  = 1'b1;
            timeout_port_d = m_q;
        end

        if (state_d != state_q) begin
            timer_d = '0;
        end else if ((state_q != ST_IDLE) && (timer_q != {TIMER_BITS{1'b1}})) begin
            timer_d = timer_q + 1'b1;
        end
    end

    // Moore outputs decoded from registered state, master and abort registers.
    always_comb begin
        bus_en       = (state_q != ST_IDLE);
        req_ready    = (state_q == ST_RESP);
        bus_control  = '0;
        if (state_q == ST_RESP) begin
            bus_control = MEM_PORT;
        end else if (state_q == ST_MASTER) begin
            bus_control = m_q;
        end
        curr_master  = '0;
        for (int i = 0; i < NUM_CACHES; i++) begin
            curr_master[i] = (state_q != ST_IDLE) && (m_q == BUS_SIG_WIDTH'(i));
        end
        timeout_err  = timeout_err_q;
        timeout_port = timeout_port_q;
        dbg_state    = state_q;
    end

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Bench for coherence_bus_arbiter: a round-robin instance with an 8-cycle
// watchdog and a fixed-priority instance with the watchdog disabled, each
// checked every cycle against a tenure-level reference model.
module tb_coherence_bus_arbiter;

    localparam int NC = 4;
    localparam int MB = 4;
    localparam int BW = 3;
    localparam int WD = 8;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [NC*MB-1:0] msg_rr = '0, msg_fp = '0;
    logic [MB-1:0]    l2_rr = '0, l2_fp = '0;

    logic [BW-1:0] bc_rr, tp_rr, bc_fp, tp_fp;
    logic          en_rr, rdy_rr, err_rr, en_fp, rdy_fp, err_fp;
    logic [NC-1:0] cm_rr, cm_fp;
    logic [1:0]    st_rr, st_fp;

    int errors = 0;
    int checks = 0;

    coherence_bus_arbiter #(
        .NUM_CACHES(NC), .MSG_BITS(MB), .ARB_MODE(0), .TIMEOUT_CYCLES(WD), .TIMER_BITS(4)
    ) dut_rr (
        .clock(clock), .reset(reset), .cache2mem_msg(msg_rr), .mem2controller_msg(l2_rr),
        .bus_control(bc_rr), .bus_en(en_rr), .curr_master(cm_rr), .req_ready(rdy_rr),
        .timeout_err(err_rr), .timeout_port(tp_rr), .dbg_state(st_rr)
    );

    coherence_bus_arbiter #(
        .NUM_CACHES(NC), .MSG_BITS(MB), .ARB_MODE(1), .TIMEOUT_CYCLES(0), .TIMER_BITS(4)
    ) dut_fp (
        .clock(clock), .reset(reset), .cache2mem_msg(msg_fp), .mem2controller_msg(l2_fp),
        .bus_control(bc_fp), .bus_en(en_fp), .curr_master(cm_fp), .req_ready(rdy_fp),
        .timeout_err(err_fp), .timeout_port(tp_fp), .dbg_state(st_fp)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    // phase: 0 = bus idle, 1 = master driving, 2 = L2 response phase.
    typedef struct {
        int phase;
        int owner;
        int last;
        int age;
        bit err;
        int tport;
    } mdl_t;

    mdl_t mrr, mfp;

    function automatic mdl_t mdl_reset();
        mdl_t s;
        s.phase = 0; s.owner = 0; s.last = NC - 1; s.age = 0; s.err = 1'b0; s.tport = 0;
        return s;
    endfunction

    function automatic int msg_of(input logic [NC*MB-1:0] bus, input int i);
        return int'(bus[i*MB +: MB]);
    endfunction

    function automatic mdl_t mdl_step(input mdl_t s, input logic [NC*MB-1:0] bus,
                                      input logic [MB-1:0] l2, input bit fixed, input int limit);
        mdl_t n;
        int   pick;
        int   c;
        int   cur;
        int   l2i;
        bit   moved;
        n = s;
        n.err = 1'b0;
        moved = 1'b0;
        l2i = int'(l2);
        cur = msg_of(bus, s.owner);
        if (s.phase == 0) begin
            pick = -1;
            for (int k = 0; k < NC; k++) begin
                c = fixed ? k : (s.last + 1 + k) % NC;
                if (pick < 0 && msg_of(bus, c) != 0) pick = c;
            end
            if (pick >= 0) begin
                n.phase = 1; n.owner = pick; moved = 1'b1;
            end
        end else if (s.phase == 1) begin
            if (l2i >= 10 && l2i <= 13) begin
                n.phase = 2; moved = 1'b1;
            end else if (cur == 0) begin
                n.phase = 0; n.last = s.owner; moved = 1'b1;
            end
        end else begin
            if (cur == 14) begin
                n.phase = 1; moved = 1'b1;
            end else if (cur == 0) begin
                n.phase = 0; n.last = s.owner; moved = 1'b1;
            end
        end
        if (s.phase != 0 && !moved && limit != 0 && s.age == limit - 1) begin
            n.phase = 0; n.last = s.owner; n.err = 1'b1; n.tport = s.owner; moved = 1'b1;
        end
        n.age = moved ? 0 : ((s.phase != 0) ? s.age + 1 : 0);
        return n;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_dut(input string tag, input mdl_t s, input int en, input int bc,
                             input int cm, input int rdy, input int err, input int tp, input int st);
        chk({tag, ".bus_en"},       en,  (s.phase != 0) ? 1 : 0);
        chk({tag, ".bus_control"},  bc,  (s.phase == 2) ? NC : ((s.phase == 1) ? s.owner : 0));
        chk({tag, ".curr_master"},  cm,  (s.phase != 0) ? (1 << s.owner) : 0);
        chk({tag, ".req_ready"},    rdy, (s.phase == 2) ? 1 : 0);
        chk({tag, ".timeout_err"},  err, int'(s.err));
        chk({tag, ".timeout_port"}, tp,  s.tport);
        chk({tag, ".state"},        st,  s.phase);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        if (!reset) begin
            mrr = mdl_reset();
            mfp = mdl_reset();
        end else begin
            mrr = mdl_step(mrr, msg_rr, l2_rr, 1'b0, WD);
            mfp = mdl_step(mfp, msg_fp, l2_fp, 1'b1, 0);
        end
        #1;
        check_dut("rr", mrr, int'(en_rr), int'(bc_rr), int'(cm_rr), int'(rdy_rr),
                  int'(err_rr), int'(tp_rr), int'(st_rr));
        check_dut("fp", mfp, int'(en_fp), int'(bc_fp), int'(cm_fp), int'(rdy_fp),
                  int'(err_fp), int'(tp_fp), int'(st_fp));
    endtask

    task automatic do_reset();
        msg_rr = '0; msg_fp = '0; l2_rr = '0; l2_fp = '0;
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    function automatic logic [NC*MB-1:0] rand_msgs(input logic [NC*MB-1:0] prev);
        logic [NC*MB-1:0] r;
        int sel;
        r = prev;
        for (int i = 0; i < NC; i++) begin
            if ($urandom_range(0, 99) < 25) begin
                sel = $urandom_range(0, 5);
                case (sel)
                    0, 1:    r[i*MB +: MB] = '0;
                    2:       r[i*MB +: MB] = 4'd1;
                    3:       r[i*MB +: MB] = 4'd14;
                    default: r[i*MB +: MB] = MB'($urandom_range(1, 15));
                endcase
            end
        end
        return r;
    endfunction

    function automatic logic [MB-1:0] rand_l2();
        logic [MB-1:0] codes [6];
        codes[0] = 4'd10; codes[1] = 4'd11; codes[2] = 4'd12;
        codes[3] = 4'd13; codes[4] = 4'd14; codes[5] = 4'd3;
        if ($urandom_range(0, 99) < 30) return codes[$urandom_range(0, 5)];
        return '0;
    endfunction

    // ---------------- stimulus table ----------------
    typedef struct {
        logic [NC*MB-1:0] msgs;
        logic [MB-1:0]    l2;
        int               en;
        int               bc;
        int               cm;
        int               rdy;
    } vec_t;

    vec_t vt [18];

    initial begin
        #200000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        int p3_grants;

        // Round-robin traffic on ports 1 and 3, hand-derived from reset (last grant = 3).
        vt[0]  = '{16'h1010, 4'd0,  1, 1, 2, 0};
        vt[1]  = '{16'h1010, 4'd0,  1, 1, 2, 0};
        vt[2]  = '{16'h1010, 4'd10, 1, 4, 2, 1};
        vt[3]  = '{16'h1000, 4'd0,  0, 0, 0, 0};
        vt[4]  = '{16'h1010, 4'd0,  1, 3, 8, 0};
        vt[5]  = '{16'h1010, 4'd0,  1, 3, 8, 0};
        vt[6]  = '{16'h1010, 4'd10, 1, 4, 8, 1};
        vt[7]  = '{16'h0010, 4'd0,  0, 0, 0, 0};
        vt[8]  = '{16'h1010, 4'd0,  1, 1, 2, 0};
        vt[9]  = '{16'h1010, 4'd11, 1, 4, 2, 1};
        vt[10] = '{16'h1010, 4'd0,  1, 4, 2, 1};
        vt[11] = '{16'h1000, 4'd0,  0, 0, 0, 0};
        vt[12] = '{16'h1010, 4'd10, 1, 3, 8, 0};
        vt[13] = '{16'h1010, 4'd0,  1, 3, 8, 0};
        vt[14] = '{16'h0010, 4'd0,  0, 0, 0, 0};
        vt[15] = '{16'h1011, 4'd0,  1, 0, 1, 0};
        vt[16] = '{16'h1011, 4'd12, 1, 4, 1, 1};
        vt[17] = '{16'h1010, 4'd0,  0, 0, 0, 0};

        mrr = mdl_reset();
        mfp = mdl_reset();

        // Reset held with every port requesting: all outputs stay low.
        msg_rr = 16'h1111; msg_fp = 16'h1111;
        reset = 1'b0;
        repeat (3) tick();
        chk("reset.bus_en", int'(en_rr), 0);
        chk("reset.curr_master", int'(cm_rr), 0);
        chk("reset.timeout_port", int'(tp_rr), 0);
        reset = 1'b1;
        tick();
        chk("first_grant.rr_bus_control", int'(bc_rr), 0);
        chk("first_grant.rr_curr_master", int'(cm_rr), 1);
        chk("first_grant.fp_curr_master", int'(cm_fp), 1);

        // Table-driven round-robin sequence.
        do_reset();
        for (int i = 0; i < 18; i++) begin
            msg_rr = vt[i].msgs;
            l2_rr  = vt[i].l2;
            tick();
            chk($sformatf("vec%0d.bus_en", i),      int'(en_rr),  vt[i].en);
            chk($sformatf("vec%0d.bus_control", i), int'(bc_rr),  vt[i].bc);
            chk($sformatf("vec%0d.curr_master", i), int'(cm_rr),  vt[i].cm);
            chk($sformatf("vec%0d.req_ready", i),   int'(rdy_rr), vt[i].rdy);
        end

        // Fixed priority: port 1 wins every tenure, port 3 starves.
        do_reset();
        p3_grants = 0;
        for (int t = 0; t < 3; t++) begin
            msg_fp = 16'h1010; l2_fp = '0;
            tick();
            chk($sformatf("fp_tenure%0d.grant", t), int'(bc_fp), 1);
            if (cm_fp[3]) p3_grants++;
            tick();
            l2_fp = 4'd10;
            tick();
            chk($sformatf("fp_tenure%0d.resp_sel", t), int'(bc_fp), 4);
            chk($sformatf("fp_tenure%0d.req_ready", t), int'(rdy_fp), 1);
            l2_fp = '0; msg_fp = 16'h1000;
            tick();
            if (cm_fp[3]) p3_grants++;
        end
        chk("fp.port3_grants", p3_grants, 0);

        // Multi-phase flush on port 2 while port 0 waits.
        do_reset();
        msg_rr = 16'h0100;
        tick();
        chk("flush.master1", int'(bc_rr), 2);
        msg_rr = 16'h0101; l2_rr = 4'd13;
        tick();
        chk("flush.resp1", int'(bc_rr), 4);
        chk("flush.resp1_owner", int'(cm_rr), 4);
        msg_rr = 16'h0E01; l2_rr = '0;
        tick();
        chk("flush.master2", int'(bc_rr), 2);
        chk("flush.master2_owner", int'(cm_rr), 4);
        msg_rr = 16'h0101; l2_rr = 4'd10;
        tick();
        chk("flush.resp2_owner", int'(cm_rr), 4);
        msg_rr = 16'h0001; l2_rr = '0;
        tick();
        chk("flush.release", int'(en_rr), 0);
        tick();
        chk("flush.next_grant", int'(cm_rr), 1);
        msg_rr = '0;
        tick();

        // Watchdog: silent L2 aborts after 8 master cycles; next grant goes to port 1.
        do_reset();
        msg_rr = 16'h0011;
        tick();
        chk("wd.grant0", int'(cm_rr), 1);
        for (int c = 0; c < 7; c++) begin
            tick();
            chk($sformatf("wd.hold%0d", c), int'(en_rr), 1);
        end
        tick();
        chk("wd.abort_idle", int'(en_rr), 0);
        chk("wd.abort_pulse", int'(err_rr), 1);
        chk("wd.abort_port", int'(tp_rr), 0);
        tick();
        chk("wd.next_grant", int'(cm_rr), 2);
        chk("wd.pulse_once", int'(err_rr), 0);
        chk("wd.port_held", int'(tp_rr), 0);
        repeat (7) tick();
        l2_rr = 4'd10;
        tick();
        chk("wd.transition_wins", int'(rdy_rr), 1);
        chk("wd.no_abort", int'(err_rr), 0);
        msg_rr = '0; l2_rr = '0;
        tick();

        // Asynchronous reset in the middle of a response phase.
        do_reset();
        msg_rr = 16'h0010;
        tick();
        l2_rr = 4'd10;
        tick();
        chk("areset.pre_ready", int'(rdy_rr), 1);
        #3;
        reset = 1'b0;
        mrr = mdl_reset();
        mfp = mdl_reset();
        #1;
        chk("areset.bus_en", int'(en_rr), 0);
        chk("areset.req_ready", int'(rdy_rr), 0);
        chk("areset.curr_master", int'(cm_rr), 0);
        msg_rr = '0; l2_rr = '0;
        tick();
        reset = 1'b1;

        // Randomized traffic on both instances against the model.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            msg_rr = rand_msgs(msg_rr);
            msg_fp = rand_msgs(msg_fp);
            l2_rr  = rand_l2();
            l2_fp  = rand_l2();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
